jtag_host_driver: RTL
=====================

// Module: jtag_host_driver
// PURPOSE
//  Bus-side JTAG master that sits directly upstream of the jtag TAP top.
//  Accepts high-level ops (TAP reset, IR scan, DR scan, idle clocks) over valid/ready.
//  Generates TCK/TMS/TDI from the system clock and captures TDO into a response word.
//  Lets on-chip logic and testbenches drive the TAP without hand-written TMS sequences.
// PARAMETERS
//  CLK_DIV  2   TCK half-period in clk cycles (>=1); one TCK period = 2*CLK_DIV clk
//  MAX_LEN  16  widest scan in bits; sizes cmd_data/rsp_data
//  LEN_W    $clog2(MAX_LEN+1)  width of cmd_len (derived, do not override)
// PORTS
//  clk        in   1        system clock; single clock domain
//  TRST       in   1        synchronous, active-high reset
//  cmd_valid  in   1        command offered
//  cmd_ready  out  1        host idle, command accepted on cmd_valid&&cmd_ready
//  cmd_op     in   2        host_op_t: OP_RESET, OP_IR, OP_DR, OP_IDLE
//  cmd_len    in   LEN_W    scan length (IR/DR) or idle TCK count (OP_IDLE)
//  cmd_data   in   MAX_LEN  TDI bits, bit 0 shifted first
//  rsp_valid  out  1        one-cycle pulse, op complete
//  rsp_data   out  MAX_LEN  captured TDO, bit i = TDO sampled during shift bit i
//  TCK        out  1        JTAG test clock to TAP
//  TMS        out  1        JTAG mode select
//  TDI        out  1        JTAG data in
//  TDO        in   1        JTAG data out from TAP
//  busy       out  1        ~cmd_ready
// BEHAVIOUR
//  - Reset values: TCK=0, TMS=1, TDI=0, cmd_ready=1, busy=0, rsp_valid=0, rsp_data=0.
//  - TCK toggles only while busy; in H_IDLE it is held at 0. TMS/TDI change only while TCK is low:
//    at op start, or in the clk cycle TCK falls. TDO is sampled in the clk cycle TCK rises,
//    using its pre-edge value.
//  - FSM (host_state_t): H_IDLE -> H_HDR -> H_SHIFT -> H_TRL [-> H_RTI] -> H_RSP -> H_IDLE.
//    Each header/shift/trailer entry is one TCK period.
//  - Header TMS, from Run-Test/Idle:
//    - OP_DR: 1,0,0.
//    - OP_IR: 1,1,0,0.
//    - OP_RESET: 1,1,1,1,1,0; no shift/trailer; lands in RTI.
//    - OP_IDLE: cmd_len periods with TMS=0; no shift/trailer.
//  - H_SHIFT: cmd_len periods, TDI=cmd_data[i], TMS=0 except last bit TMS=1 (Exit1).
//  - Trailer TMS: 1,0 (Update, RTI).
//  - cmd_len clamping:
//    - cmd_len=0 on IR/DR: header ends with TMS=1 at Capture (DR: 1,0,1; IR: 1,1,0,1),
//      then trailer 1,0; rsp_data=0.
//    - cmd_len>MAX_LEN: clamps to MAX_LEN.
//  - Op latency: cmd accept cycle + (#TCK periods * 2*CLK_DIV) clk, then rsp_valid pulses for 1 clk.
//  - cmd_ready re-asserts in that same cycle, so back-to-back ops are legal.
//  - rsp_data bits >= len are 0. OP_RESET/OP_IDLE return rsp_data=0. rsp_data holds until next rsp_valid.
//  - cmd_valid while busy is ignored; cmd fields are registered at accept, later changes have no effect.
//  - TRST mid-op: next clk all outputs return to reset values; no rsp_valid. Target TAP state is then
//    unknown, and the issuer must send OP_RESET.
// CONFIGURATION
//  JTAG_HOST_RTI_WAIT_EN defined:
//    - Adds parameter RTI_CYCLES (default 4).
//    - After every IR/DR trailer, H_RTI emits RTI_CYCLES extra TCK periods with TMS=0
//      before rsp_valid.
//  JTAG_HOST_RTI_WAIT_EN undefined: H_RTI does not exist; trailer goes straight to H_RSP.
// STRUCTURE
//  - jtag_types_pkg gains: host_op_t (2-bit enum), host_state_t, localparams
//    HDR_DR=3'b001/len3, HDR_IR=4'b0011/len4, RST_SEQ=6'b011111/len6 (LSB first).
//  - Sub-module jtag_tck_gen: CLK_DIV counter producing TCK, tck_rise and tck_fall strobes;
//    enable input; synchronous clear on TRST.
//  - Top holds the FSM, bit counter, TDI shift register and TDO capture register.
// TESTING
//  Bench TDO model: 1-bit flop loading TDI on TCK rise (one-bit delay, init 0). CLK_DIV=2.
//  1. OP_RESET after TRST -> 6 TCK rises, TMS 1,1,1,1,1,0; rsp_valid once, 24 clk after accept; rsp_data=0.
//  2. OP_DR len 8 data 8'hA5 -> TMS 1,0,0,0*7,1,1,0; TDI on shifts 1,0,1,0,0,1,0,1; rsp_data=8'h4A.
//  3. OP_IR len 0 -> TMS 1,1,0,1,1,0, no TDI activity; rsp_data=0.
//  4. OP_DR len 20 (MAX_LEN 16) data 16'hFFFF -> exactly 16 shift periods; rsp_data=16'hFFFE.
//  5. TRST asserted at shift bit 3 -> next clk TCK=0, TMS=1, cmd_ready=1; no rsp_valid ever for that op.
//  6. Two ops back-to-back, cmd_valid held -> second accepted in rsp_valid cycle of first;
//     no TCK gap beyond 1 clk.

Source files
------------

// File: rtl/jtag_types_pkg.sv
// Shared types and fixed TMS sequences for the JTAG host driver.
// JTAG_HOST_RTI_WAIT_EN adds the H_RTI state.
package jtag_types_pkg;

  typedef enum logic [1:0] {
    OP_RESET = 2'd0,
    OP_IR    = 2'd1,
    OP_DR    = 2'd2,
    OP_IDLE  = 2'd3
  } host_op_t;

`ifdef JTAG_HOST_RTI_WAIT_EN
  typedef enum logic [2:0] {
    H_IDLE  = 3'd0,
    H_HDR   = 3'd1,
    H_SHIFT = 3'd2,
    H_TRL   = 3'd3,
    H_RTI   = 3'd4,
    H_RSP   = 3'd5
  } host_state_t;
`else
  typedef enum logic [2:0] {
    H_IDLE  = 3'd0,
    H_HDR   = 3'd1,
    H_SHIFT = 3'd2,
    H_TRL   = 3'd3,
    H_RSP   = 3'd5
  } host_state_t;
`endif

  // TMS sequences from Run-Test/Idle, bit 0 driven first.
  localparam logic [2:0]  HDR_DR      = 3'b001;
  localparam int unsigned HDR_DR_LEN  = 3;
  localparam logic [3:0]  HDR_IR      = 4'b0011;
  localparam int unsigned HDR_IR_LEN  = 4;
  localparam logic [5:0]  RST_SEQ     = 6'b011111;
  localparam int unsigned RST_SEQ_LEN = 6;

  // A zero-length scan leaves Capture with TMS=1, skipping Shift entirely.
  function automatic logic hdr_tms(host_op_t op, logic [2:0] idx, logic zero_len);
    logic t;
    t = 1'b0;
    unique case (op)
      OP_RESET: t = RST_SEQ[idx];
      OP_IR:    t = (zero_len && idx == 3'd3) ? 1'b1 : HDR_IR[idx[1:0]];
      OP_DR:    t = (zero_len && idx == 3'd2) ? 1'b1 : HDR_DR[idx[1:0]];
      default:  t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/jtag_tck_gen.sv
// TCK divider: half-period of CLK_DIV clk cycles while enabled, held low otherwise.
module jtag_tck_gen #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tck_o,
  output logic tck_rise_o,
  output logic tck_fall_o
);

  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            tck_q, tck_d;
  logic            toggle;

  assign toggle = en_i && (cnt_q == CntW'(CLK_DIV - 1));

  always_comb begin
    cnt_d = cnt_q;
    tck_d = tck_q;
    if (!en_i) begin
      cnt_d = '0;
      tck_d = 1'b0;
    end else if (toggle) begin
      cnt_d = '0;
      tck_d = ~tck_q;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      cnt_q <= '0;
      tck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tck_q <= tck_d;
    end
  end

  // Strobes mark the clk cycle at whose closing edge TCK changes.
  assign tck_o      = tck_q;
  assign tck_rise_o = toggle && !tck_q;
  assign tck_fall_o = toggle && tck_q;

endmodule

// File: rtl/jtag_host_driver.sv
// Bus-side JTAG master: turns reset/IR/DR/idle ops into TCK/TMS/TDI and captures TDO.
// JTAG_HOST_RTI_WAIT_EN adds RTI_CYCLES idle TCK periods after every IR/DR scan.
module jtag_host_driver
  import jtag_types_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned MAX_LEN    = 16,
`ifdef JTAG_HOST_RTI_WAIT_EN
  parameter int unsigned RTI_CYCLES = 4,
`endif
  localparam int unsigned LEN_W     = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               TRST,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  host_op_t           cmd_op,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               TCK,
  output logic               TMS,
  output logic               TDI,
  input  logic               TDO,
  output logic               busy
);

  localparam int unsigned CNT_W = (LEN_W > 8) ? LEN_W : 8;
  localparam int unsigned IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  host_state_t        state_q, state_d;
  host_op_t           op_q, op_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic [MAX_LEN-1:0] data_q, data_d;
  logic [MAX_LEN-1:0] cap_q, cap_d;
  logic [MAX_LEN-1:0] rsp_q, rsp_d;
  logic               tms_q, tms_d;
  logic               tdi_q, tdi_d;

  logic               tck_en, tck_rise, tck_fall;
  logic               accept;
  logic [LEN_W-1:0]   len_clamp;
  logic [CNT_W-1:0]   len_ext;

  function automatic logic [CNT_W-1:0] hdr_last(host_op_t op, logic [LEN_W-1:0] len);
    logic [CNT_W-1:0] l;
    unique case (op)
      OP_RESET: l = CNT_W'(RST_SEQ_LEN - 1);
      OP_IR:    l = CNT_W'(HDR_IR_LEN - 1);
      OP_DR:    l = CNT_W'(HDR_DR_LEN - 1);
      default:  l = CNT_W'(len) - CNT_W'(1);
    endcase
    return l;
  endfunction

  assign cmd_ready = (state_q == H_IDLE) || (state_q == H_RSP);
  assign busy      = ~cmd_ready;
  assign rsp_valid = (state_q == H_RSP);
  assign rsp_data  = rsp_q;
  assign TMS       = tms_q;
  assign TDI       = tdi_q;
  assign tck_en    = busy;
  assign accept    = cmd_valid && cmd_ready;
  assign len_clamp = (cmd_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cmd_len;
  assign len_ext   = CNT_W'(len_q);

  jtag_tck_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tck_gen (
    .clk_i     (clk),
    .clr_i     (TRST),
    .en_i      (tck_en),
    .tck_o     (TCK),
    .tck_rise_o(tck_rise),
    .tck_fall_o(tck_fall)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    len_d   = len_q;
    idx_d   = idx_q;
    data_d  = data_q;
    cap_d   = cap_q;
    rsp_d   = rsp_q;
    tms_d   = tms_q;
    tdi_d   = tdi_q;

    unique case (state_q)
      H_IDLE, H_RSP: begin
        state_d = H_IDLE;
        if (accept) begin
          op_d    = cmd_op;
          len_d   = len_clamp;
          idx_d   = '0;
          data_d  = cmd_data;
          cap_d   = '0;
          tdi_d   = 1'b0;
          tms_d   = hdr_tms(cmd_op, 3'd0, len_clamp == '0);
          // A zero-count idle has no TCK periods, so it completes immediately.
          if (cmd_op == OP_IDLE && len_clamp == '0) begin
            state_d = H_RSP;
            rsp_d   = '0;
          end else begin
            state_d = H_HDR;
          end
        end
      end

      H_HDR: begin
        if (tck_fall) begin
          if (idx_q == hdr_last(op_q, len_q)) begin
            idx_d = '0;
            if (op_q == OP_RESET || op_q == OP_IDLE) begin
              state_d = H_RSP;
              rsp_d   = cap_q;
            end else if (len_q == '0) begin
              state_d = H_TRL;
              tms_d   = 1'b1;
            end else begin
              state_d = H_SHIFT;
              tms_d   = (len_q == LEN_W'(1));
              tdi_d   = data_q[0];
            end
          end else begin
            idx_d = idx_q + CNT_W'(1);
            tms_d = hdr_tms(op_q, idx_d[2:0], len_q == '0);
          end
        end
      end

      H_SHIFT: begin
        if (tck_rise) begin
          cap_d[idx_q[IDX_W-1:0]] = TDO;
        end
        if (tck_fall) begin
          if (idx_q + CNT_W'(1) == len_ext) begin
            state_d = H_TRL;
            idx_d   = '0;
            tms_d   = 1'b1;
            tdi_d   = 1'b0;
          end else begin
            idx_d  = idx_q + CNT_W'(1);
            data_d = data_q >> 1;
            tdi_d  = data_d[0];
            tms_d  = (idx_q + CNT_W'(2) == len_ext);
          end
        end
      end

      H_TRL: begin
        if (tck_fall) begin
          if (idx_q == '0) begin
            idx_d = CNT_W'(1);
            tms_d = 1'b0;
          end else begin
            idx_d = '0;
`ifdef JTAG_HOST_RTI_WAIT_EN
            if (RTI_CYCLES == 0) begin
              state_d = H_RSP;
              rsp_d   = cap_q;
            end else begin
              state_d = H_RTI;
              tms_d   = 1'b0;
            end
`else
            state_d = H_RSP;
            rsp_d   = cap_q;
`endif
          end
        end
      end

`ifdef JTAG_HOST_RTI_WAIT_EN
      H_RTI: begin
        if (tck_fall) begin
          if (idx_q == CNT_W'(RTI_CYCLES - 1)) begin
            state_d = H_RSP;
            idx_d   = '0;
            rsp_d   = cap_q;
          end else begin
            idx_d = idx_q + CNT_W'(1);
          end
        end
      end
`endif

      default: state_d = H_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (TRST) begin
      state_q <= H_IDLE;
      op_q    <= OP_RESET;
      len_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      cap_q   <= '0;
      rsp_q   <= '0;
      tms_q   <= 1'b1;
      tdi_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      cap_q   <= cap_d;
      rsp_q   <= rsp_d;
      tms_q   <= tms_d;
      tdi_q   <= tdi_d;
    end
  end

endmodule
